// File: rtl/flag_branch_resolver_pkg.sv
// Shared types for the condition-flag reader: branch op encoding, condition
// codes, flag bit positions, resolver state and small decision helpers.
package branch_pkg;

  typedef enum logic [1:0] {
    OP_BCOND = 2'd0,
    OP_CBZ   = 2'd1,
    OP_CBNZ  = 2'd2,
    OP_B     = 2'd3
  } op_e;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_HS = 4'd2;
  localparam logic [3:0] COND_LO = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Flag register layout is {N,C,V,Z}.
  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // AL and NV are unconditional, so only the first fourteen codes read flags.
  function automatic logic needs_flags(op_e op, logic [3:0] cond);
    return (op == OP_BCOND) && (cond < COND_AL);
  endfunction

  function automatic logic resolve_taken(op_e op, logic cond_pass, logic zero);
    logic taken;
    case (op)
      OP_BCOND: taken = cond_pass;
      OP_CBZ:   taken = zero;
      OP_CBNZ:  taken = !zero;
      default:  taken = 1'b1;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/flag_branch_resolver_if.sv
// Decode-side request, flag inputs, PC-select response and counters of the
// branch resolver, bundled so both ends agree on direction.
interface flag_branch_resolver_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [3:0]       in_cond;
  logic             in_zero;
  logic [TAG_W-1:0] in_tag;
  logic [3:0]       flag_q;
  logic             fwd_valid;
  logic [3:0]       fwd_flags;
  logic             flag_pending;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] nottaken_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_op, in_cond, in_zero, in_tag,
           flag_q, fwd_valid, fwd_flags, flag_pending, flush, out_ready,
    input  in_ready, out_valid, out_taken, out_tag,
           taken_cnt, nottaken_cnt, stall_cnt
  );

  modport slave (
    input  in_valid, in_op, in_cond, in_zero, in_tag,
           flag_q, fwd_valid, fwd_flags, flag_pending, flush, out_ready,
    output in_ready, out_valid, out_taken, out_tag,
           taken_cnt, nottaken_cnt, stall_cnt
  );

endinterface

// File: rtl/flag_branch_resolver_cond_eval.sv
// Combinational condition-code evaluator: {N,C,V,Z} plus a 4-bit condition
// code gives pass/fail. Kept standalone so conditional-select can reuse it.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] cond_i,
  output logic       pass_o
);

  logic n, c, v, z;

  assign n = flags_i[FLAG_N];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];
  assign z = flags_i[FLAG_Z];

  always_comb begin
    // NOTE: default assigned before the case so every path drives pass_o and no latch is inferred.
    pass_o = 1'b1;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_HS: pass_o = c;
      COND_LO: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_resolver.sv
// Conditional-branch resolver: picks forwarded or architectural flags, stalls
// on an in-flight flag writer, and hands a registered decision to PC select.
module flag_branch_resolver
  import branch_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  flag_branch_resolver_if.slave  bus
);

  state_e           state_q;
  op_e              op_q;
  logic [3:0]       cond_q;
  logic             out_taken_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [CNT_W-1:0] taken_cnt_q;
  logic [CNT_W-1:0] nottaken_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [3:0] sel_flags;
  logic [3:0] eval_cond;
  logic       cond_pass;
  logic       in_ready;
  logic       accept;
  logic       handshake;
  logic       new_taken;
  logic       held_taken;
  op_e        in_op;

  assign in_op     = op_e'(bus.in_op);
  assign sel_flags = bus.fwd_valid ? bus.fwd_flags : bus.flag_q;

  // One evaluator serves both the incoming op and the op parked in WAIT.
  assign eval_cond = (state_q == ST_WAIT) ? cond_q : bus.in_cond;

  cond_eval u_cond_eval (
    .flags_i (sel_flags),
    .cond_i  (eval_cond),
    .pass_o  (cond_pass)
  );

  // Flush outranks both a new accept and a DONE handshake.
  assign in_ready  = !bus.flush &&
                     ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
  assign accept    = bus.in_valid && in_ready;
  assign handshake = (state_q == ST_DONE) && bus.out_ready && !bus.flush;

  assign new_taken  = resolve_taken(in_op, cond_pass, bus.in_zero);
  assign held_taken = resolve_taken(op_q, cond_pass, 1'b0);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every register update in this block sees pre-edge values.
    if (!reset) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_BCOND;
      cond_q         <= '0;
      out_taken_q    <= 1'b0;
      out_tag_q      <= '0;
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else if (bus.flush) begin
      state_q <= ST_IDLE;
    end else begin
      if (handshake) begin
        if (out_taken_q) begin
          if (taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 1'b1;
        end else begin
          if (nottaken_cnt_q != '1) nottaken_cnt_q <= nottaken_cnt_q + 1'b1;
        end
      end

      if ((state_q == ST_WAIT) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end

      // accept covers both IDLE and a back-to-back take during a DONE handshake.
      if (accept) begin
        out_tag_q <= bus.in_tag;
        if (needs_flags(in_op, bus.in_cond) && bus.flag_pending) begin
          op_q    <= in_op;
          cond_q  <= bus.in_cond;
          state_q <= ST_WAIT;
        end else begin
          out_taken_q <= new_taken;
          state_q     <= ST_DONE;
        end
      end else begin
        case (state_q)
          ST_WAIT: begin
            if (!bus.flag_pending) begin
              out_taken_q <= held_taken;
              state_q     <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (bus.out_ready) state_q <= ST_IDLE;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = (state_q == ST_DONE);
  assign bus.out_taken    = out_taken_q;
  assign bus.out_tag      = out_tag_q;
  assign bus.taken_cnt    = taken_cnt_q;
  assign bus.nottaken_cnt = nottaken_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_flag_branch_resolver.sv
// Self-checking bench for flag_branch_resolver: scoreboard of expected
// decisions plus directed checks of stall, hold, flush, saturation and reset.
module tb_flag_branch_resolver;
  import branch_pkg::*;

  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic             taken;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  flag_branch_resolver_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  flag_branch_resolver #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int               n_checks = 0;
  int               n_errors = 0;
  exp_t             sb[$];
  logic [CNT_W-1:0] exp_taken_cnt = '0;
  logic [CNT_W-1:0] exp_nt_cnt    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference for the condition table.
  function automatic logic model_cond(input logic [3:0] f, input logic [3:0] cond);
    logic n, c, v, z, r;
    n = f[3]; c = f[2]; v = f[1]; z = f[0];
    case (cond)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = c;
      4'd3:    r = !c;
      4'd4:    r = n;
      4'd5:    r = !n;
      4'd6:    r = v;
      4'd7:    r = !v;
      4'd8:    r = c & !z;
      4'd9:    r = !c | z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = !z & (n == v);
      4'd13:   r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic model_taken(input logic [1:0] op, input logic [3:0] cond,
                                       input logic zero, input logic [3:0] flags);
    case (op)
      2'd0:    return model_cond(flags, cond);
      2'd1:    return zero;
      2'd2:    return !zero;
      default: return 1'b1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, push its expected decision when it is seen to be accepted.
  task automatic send(input logic [1:0] op, input logic [3:0] cond, input logic zero,
                      input logic [TAG_W-1:0] tag, input logic exp_taken);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_cond  = cond;
    bus.in_zero  = zero;
    bus.in_tag   = tag;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.taken = exp_taken;
        e.tag   = tag;
        sb.push_back(e);
        ok = 1'b1;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Output monitor: every completed handshake is compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.out_valid && bus.out_ready && !bus.flush) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_taken", bus.out_taken, e.taken);
        check("sb_tag", bus.out_tag, e.tag);
        if (e.taken) begin
          if (exp_taken_cnt != '1) exp_taken_cnt++;
        end else begin
          if (exp_nt_cnt != '1) exp_nt_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] fl;
    logic [1:0] op;
    logic [3:0] cond;
    logic       zero;

    bus.in_valid     = 1'b0;
    bus.in_op        = 2'd0;
    bus.in_cond      = 4'd0;
    bus.in_zero      = 1'b0;
    bus.in_tag       = '0;
    bus.flag_q       = 4'd0;
    bus.fwd_valid    = 1'b0;
    bus.fwd_flags    = 4'd0;
    bus.flag_pending = 1'b0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_taken", bus.out_taken, 1'b0);
    check("rst_out_tag", bus.out_tag, '0);
    check("rst_taken_cnt", bus.taken_cnt, '0);
    check("rst_nottaken_cnt", bus.nottaken_cnt, '0);
    check("rst_stall_cnt", bus.stall_cnt, '0);
    step();
    reset = 1'b1;

    // BCOND EQ on architectural Z=1, one-cycle latency
    step();
    bus.flag_q = 4'b0001;
    send(OP_BCOND, COND_EQ, 1'b0, 4'd1, model_taken(OP_BCOND, COND_EQ, 1'b0, 4'b0001));
    @(negedge clk);
    check("t1_valid", bus.out_valid, 1'b1);
    check("t1_taken", bus.out_taken, 1'b1);
    step();
    @(negedge clk);
    check("t1_taken_cnt", bus.taken_cnt, 4'd1);

    // BCOND GE: forwarded flags win over architectural flags
    step();
    bus.flag_q    = 4'b1000;
    bus.fwd_valid = 1'b1;
    bus.fwd_flags = 4'b1010;
    send(OP_BCOND, COND_GE, 1'b0, 4'd2, model_taken(OP_BCOND, COND_GE, 1'b0, 4'b1010));
    bus.fwd_valid = 1'b0;
    @(negedge clk);
    check("t2_fwd_taken", bus.out_taken, 1'b1);

    // BCOND NE stalled three cycles, resolved with forwarded Z=1
    step();
    bus.flag_q       = 4'b0000;
    bus.flag_pending = 1'b1;
    send(OP_BCOND, COND_NE, 1'b0, 4'd3, model_taken(OP_BCOND, COND_NE, 1'b0, 4'b0001));
    @(negedge clk);
    check("t3_stall_ready_w1", bus.in_ready, 1'b0);
    step();
    @(negedge clk);
    check("t3_stall_ready_w2", bus.in_ready, 1'b0);
    check("t3_stall_valid_w2", bus.out_valid, 1'b0);
    step();
    bus.flag_pending = 1'b0;
    bus.fwd_valid    = 1'b1;
    bus.fwd_flags    = 4'b0001;
    @(negedge clk);
    check("t3_stall_ready_w3", bus.in_ready, 1'b0);
    check("t3_stall_valid_w3", bus.out_valid, 1'b0);
    step();
    bus.fwd_valid = 1'b0;
    @(negedge clk);
    check("t3_stall_cnt", bus.stall_cnt, 4'd3);
    check("t3_valid", bus.out_valid, 1'b1);
    check("t3_taken", bus.out_taken, 1'b0);
    step();
    @(negedge clk);
    check("t3_nottaken_cnt", bus.nottaken_cnt, 4'd1);

    // CBZ ignores flag_pending; CBNZ accepted in the same cycle as the handshake
    step();
    bus.flag_pending = 1'b1;
    send(OP_CBZ, COND_NE, 1'b1, 4'd4, model_taken(OP_CBZ, COND_NE, 1'b1, bus.flag_q));
    bus.in_valid = 1'b1;
    bus.in_op    = OP_CBNZ;
    bus.in_cond  = COND_EQ;
    bus.in_zero  = 1'b1;
    bus.in_tag   = 4'd5;
    @(negedge clk);
    check("t4_cbz_valid", bus.out_valid, 1'b1);
    check("t4_cbz_taken", bus.out_taken, 1'b1);
    check("t4_b2b_ready", bus.in_ready, 1'b1);
    sb.push_back(exp_t'{taken: model_taken(OP_CBNZ, COND_EQ, 1'b1, bus.flag_q), tag: 4'd5});
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t4_b2b_valid", bus.out_valid, 1'b1);
    check("t4_b2b_taken", bus.out_taken, 1'b0);
    check("t4_b2b_tag", bus.out_tag, 4'd5);
    step();
    bus.flag_pending = 1'b0;

    // Back-pressure in DONE holds outputs; flush beats a simultaneous handshake
    bus.out_ready = 1'b0;
    send(OP_B, COND_LO, 1'b0, 4'd6, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("t5_hold_valid", bus.out_valid, 1'b1);
      check("t5_hold_taken", bus.out_taken, 1'b1);
      check("t5_hold_tag", bus.out_tag, 4'd6);
      check("t5_hold_ready", bus.in_ready, 1'b0);
      step();
    end
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t5_flush_ready", bus.in_ready, 1'b0);
    step();
    bus.flush = 1'b0;
    void'(sb.pop_front());
    @(negedge clk);
    check("t5_flush_valid", bus.out_valid, 1'b0);
    check("t5_flush_taken_cnt", bus.taken_cnt, 4'd3);
    check("t5_flush_nottaken_cnt", bus.nottaken_cnt, 4'd2);

    // Random back-to-back ops across all op types and condition codes
    step();
    for (int i = 0; i < 24; i++) begin
      op            = 2'($urandom_range(0, 3));
      cond          = 4'($urandom_range(0, 15));
      zero          = 1'($urandom_range(0, 1));
      bus.flag_q    = 4'($urandom_range(0, 15));
      bus.fwd_valid = 1'($urandom_range(0, 1));
      bus.fwd_flags = 4'($urandom_range(0, 15));
      fl = bus.fwd_valid ? bus.fwd_flags : bus.flag_q;
      send(op, cond, zero, 4'(i), model_taken(op, cond, zero, fl));
    end
    bus.fwd_valid = 1'b0;
    step();
    @(negedge clk);
    check("rand_taken_cnt", bus.taken_cnt, exp_taken_cnt);
    check("rand_nottaken_cnt", bus.nottaken_cnt, exp_nt_cnt);

    // Taken counter saturates at 2^CNT_W-1
    step();
    for (int i = 0; i < 16; i++) begin
      send(OP_B, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'(i), 1'b1);
    end
    step();
    @(negedge clk);
    check("sat_taken_cnt", bus.taken_cnt, 4'd15);
    check("sat_taken_model", bus.taken_cnt, exp_taken_cnt);
    check("sat_nottaken_cnt", bus.nottaken_cnt, exp_nt_cnt);
    check("sb_drained", sb.size(), 0);

    // Asynchronous reset while parked in WAIT
    step();
    bus.flag_pending = 1'b1;
    send(OP_BCOND, COND_EQ, 1'b0, 4'd7, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_ready", bus.in_ready, 1'b1);
    check("arst_tag", bus.out_tag, '0);
    check("arst_taken_cnt", bus.taken_cnt, '0);
    check("arst_stall_cnt", bus.stall_cnt, '0);
    sb.delete();
    bus.flag_pending = 1'b0;
    step();
    reset = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/flag_branch_resolver.md
Name: flag_branch_resolver

Overview:
Reader side of the ALU condition-flag register. Accepts conditional-branch ops (B.cond, CBZ, CBZ-not, B) from decode and picks the flag source: forwarded ALU flags, else architectural flags. Stalls while a flag-setting op is still in flight, then emits a registered taken/not-taken decision to the fetch/PC-select logic over a valid/ready handshake. Keeps saturating performance counters.

Parameters:
TAG_W, 4, width of the opaque branch tag passed through to the output
CNT_W, 16, width of each saturating performance counter

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  branch op offered
in_ready  out  1  resolver can accept op this cycle
in_op  in  2  0=BCOND, 1=CBZ, 2=CBNZ, 3=B (unconditional)
in_cond  in  4  condition code for BCOND (ARM/LEGv8 encoding)
in_zero  in  1  register operand == 0 (CBZ/CBNZ only)
in_tag  in  TAG_W  opaque tag
flag_q  in  4  architectural flags {N,C,V,Z} (bit3..bit0)
fwd_valid  in  1  ALU writes flags at next edge
fwd_flags  in  4  those flags, {N,C,V,Z}
flag_pending  in  1  older flag-setting op not yet at ALU
flush  in  1  synchronous kill of held op
out_valid  out  1  decision valid
out_ready  in  1  consumer takes decision
out_taken  out  1  1 = branch taken
out_tag  out  TAG_W  tag of resolved op
taken_cnt  out  CNT_W  resolved-taken count
nottaken_cnt  out  CNT_W  resolved-not-taken count
stall_cnt  out  CNT_W  cycles spent in WAIT

Behaviour:
- Reset (reset=0, async): state IDLE; out_valid=0, out_taken=0, out_tag=0; all counters 0.
- Flag select: fwd_valid ? fwd_flags : flag_q. Forwarding takes priority in every cycle the flags are evaluated.
- Condition table: 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 1.
- Op result: CBZ taken=in_zero; CBNZ taken=!in_zero; B taken=1. None of these read flags or wait.
- Flag dependency: only BCOND with cond<14 needs flags.
- States:
  - IDLE: in_ready=1. On accept, if the op needs flags and flag_pending=1, capture op/cond/tag and go to WAIT. Otherwise evaluate now, register the result and go to DONE.
  - WAIT: in_ready=0. stall_cnt+1 each cycle. When flag_pending=0, evaluate with the selected flags that cycle and go to DONE. Otherwise stay.
  - DONE: out_valid=1 and outputs stable; in_ready=out_ready. On out_ready, the handshake completes. If a new op is accepted that same cycle, apply the IDLE rules to it (back-to-back, no bubble); else go to IDLE.
- Latency: accept at edge N with no stall gives out_valid high after edge N (one cycle). A stall adds k cycles, where k = number of WAIT cycles.
- Counters: taken_cnt or nottaken_cnt +1 on each output handshake. All counters saturate at 2^CNT_W-1 (no wrap).
- flush=1: next state IDLE, out_valid=0, held op dropped, no counter change. Flush wins over a simultaneous accept or handshake: in_ready is forced to 0 while flush=1.
- reset asserted mid-WAIT/DONE: immediate return to reset values.
- in_cond and in_zero are ignored for ops that do not use them.

Decomposition:
- Package branch_pkg: op enum (BCOND/CBZ/CBNZ/B), 4-bit cond-code constants, flag bit indices (N=3, C=2, V=1, Z=0), state enum.
- Sub-module cond_eval (combinational): flags[3:0] + cond[3:0] -> pass. Shared later with conditional-select logic.

Test Plan:
- Reset, then BCOND EQ with flag_q=4'b0001, no fwd/pending -> next cycle out_valid=1, out_taken=1; out_ready=1 -> taken_cnt=1.
- BCOND GE, flag_q=4'b1000, fwd_valid=1 with fwd_flags=4'b1010 -> taken=1 (fwd N=V), not flag_q result 0.
- BCOND NE with flag_pending=1 for 3 cycles, then 0 with fwd_flags=4'b0001 -> in_ready=0 during stall, stall_cnt=3, out_taken=0.
- CBZ in_zero=1 while flag_pending=1 -> no stall, out_taken=1 after one cycle; then CBNZ accepted the same cycle as the handshake -> out_valid stays 1, out_taken=0.
- out_ready=0 for 4 cycles in DONE -> out_valid, out_taken, out_tag held constant, in_ready=0; flush on cycle 3 -> out_valid=0, counters unchanged.
- Preload via 2^CNT_W-1 taken handshakes (CNT_W=4: 15), one more taken -> taken_cnt stays 15.
